muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Purpose : request/response bundle between the datapath and the RV32M multiply/divide unit.
// Signals : start, funct3, operand_a, operand_b, dest_address (requester -> unit)
//           busy, done, write_data, write_address, write_enable (unit -> register file / stall logic)
// Modports: master = requester side, slave = muldiv_unit side.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  start;
    logic [2:0]            funct3;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [ADDR_WIDTH-1:0] dest_address;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      write_data;
    logic [ADDR_WIDTH-1:0] write_address;
    logic                  write_enable;

    modport master (
        output start, funct3, operand_a, operand_b, dest_address,
        input  busy, done, write_data, write_address, write_enable
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, dest_address,
        output busy, done, write_data, write_address, write_enable
    );
endinterface

// File: rtl/muldiv_unit.sv
// Purpose : iterative RV32M multiply/divide unit, fixed latency of WIDTH+1 cycles from
//           the accepting edge to done (33 for WIDTH=32), for every op including special cases.
// Ports   : clock  - rising-edge clock
//           reset  - asynchronous active-high reset; abandons any operation in flight
//           mdu    - slave side of muldiv_unit_if (request in, register-file write port out)
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic        clock,
    input  logic        reset,
    muldiv_unit_if.slave mdu
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_counter;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2*WIDTH-1:0]    r_acc;       // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]      r_mcand;     // multiplicand or divisor magnitude
    logic [WIDTH:0]        r_rem;       // partial remainder, extra bit exposes trial borrow
    logic [WIDTH-1:0]      r_q;         // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]      r_dividend;  // raw dividend for the divide-by-zero remainder
    logic                  r_neg;
    logic                  r_div_zero;
    logic                  r_ovf;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [WIDTH-1:0]      w_abs_a;
    logic [WIDTH-1:0]      w_abs_b;
    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic                  w_neg;
    logic                  w_ovf;
    logic [WIDTH:0]        w_sum;
    logic [2*WIDTH-1:0]    w_acc_next;
    logic [WIDTH:0]        w_shift;
    logic [WIDTH:0]        w_trial;
    logic [2*WIDTH-1:0]    w_prod;
    logic [WIDTH-1:0]      w_quot;
    logic [WIDTH-1:0]      w_remr;
    logic [WIDTH-1:0]      w_result;

    // Operand conditioning at accept time: magnitudes for signed operands and the result sign.
    always_comb begin
        w_a_neg = mdu.operand_a[WIDTH-1];
        w_b_neg = mdu.operand_b[WIDTH-1];
        w_abs_a = w_a_neg ? (~mdu.operand_a + WIDTH'(1)) : mdu.operand_a;
        w_abs_b = w_b_neg ? (~mdu.operand_b + WIDTH'(1)) : mdu.operand_b;
        w_mag_a = mdu.operand_a;
        w_mag_b = mdu.operand_b;
        w_neg   = 1'b0;
        case (mdu.funct3)
            F_MULH, F_DIV: begin
                w_mag_a = w_abs_a;
                w_mag_b = w_abs_b;
                w_neg   = w_a_neg ^ w_b_neg;
            end
            F_MULHSU: begin
                w_mag_a = w_abs_a;
                w_neg   = w_a_neg;
            end
            F_REM: begin
                w_mag_a = w_abs_a;
                w_mag_b = w_abs_b;
                w_neg   = w_a_neg;
            end
            default: ;
        endcase
        w_ovf = ((mdu.funct3 == F_DIV) || (mdu.funct3 == F_REM)) &&
                (mdu.operand_a == MIN_NEG) && (mdu.operand_b == '1);
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_acc_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
        w_shift    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_mcand};
    end

    // Sign correction and result selection; special cases override the iterated value.
    always_comb begin
        w_prod   = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
        w_quot   = r_neg ? (~r_q + WIDTH'(1)) : r_q;
        w_remr   = r_neg ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];
        w_result = '0;
        case (r_funct3)
            F_MUL:                      w_result = w_prod[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU:  w_result = w_prod[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU: begin
                if (r_div_zero)      w_result = '1;
                else if (r_ovf)      w_result = MIN_NEG;
                else                 w_result = w_quot;
            end
            F_REM, F_REMU: begin
                if (r_div_zero)      w_result = r_dividend;
                else if (r_ovf)      w_result = '0;
                else                 w_result = w_remr;
            end
            default: ;
        endcase
    end

    // Control FSM and datapath registers. The final count (counter==WIDTH) is a dedicated
    // correction/select cycle so the negate stays off the iteration path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_counter         <= '0;
            r_funct3          <= '0;
            r_addr            <= '0;
            r_acc             <= '0;
            r_mcand           <= '0;
            r_rem             <= '0;
            r_q               <= '0;
            r_dividend        <= '0;
            r_neg             <= 1'b0;
            r_div_zero        <= 1'b0;
            r_ovf             <= 1'b0;
            mdu.busy          <= 1'b0;
            mdu.done          <= 1'b0;
            mdu.write_enable  <= 1'b0;
            mdu.write_data    <= '0;
            mdu.write_address <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.start) begin
                        r_state    <= S_RUN;
                        r_counter  <= '0;
                        r_funct3   <= mdu.funct3;
                        r_addr     <= mdu.dest_address;
                        r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mcand    <= w_mag_b;
                        r_rem      <= '0;
                        r_q        <= w_mag_a;
                        r_dividend <= mdu.operand_a;
                        r_neg      <= w_neg;
                        r_div_zero <= (mdu.operand_b == '0);
                        r_ovf      <= w_ovf;
                        mdu.busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_counter <= r_counter + CNT_W'(1);
                    if (r_counter == CNT_W'(WIDTH)) begin
                        r_state           <= S_FINISH;
                        mdu.write_data    <= w_result;
                        mdu.write_address <= r_addr;
                        mdu.done          <= 1'b1;
                        mdu.write_enable  <= (r_addr != '0);
                    end else if (r_funct3[2]) begin
                        if (w_trial[WIDTH]) begin
                            r_rem <= w_shift;
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end else begin
                            r_rem <= w_trial;
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        r_acc <= w_acc_next;
                    end
                end
                S_FINISH: begin
                    r_state          <= S_IDLE;
                    mdu.busy         <= 1'b0;
                    mdu.done         <= 1'b0;
                    mdu.write_enable <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    muldiv_unit_if #(.WIDTH(32), .ADDR_WIDTH(5)) mdu ();

    muldiv_unit #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock (clk),
        .reset (rst),
        .mdu   (mdu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and check latency, result, write port and the one-cycle done pulse.
    // With inject set, a conflicting start is pulsed in the middle of RUN.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input bit inject);
        int cycles;
        bit found;
        @(negedge clk);
        mdu.start        = 1'b1;
        mdu.funct3       = f;
        mdu.operand_a    = a;
        mdu.operand_b    = b;
        mdu.dest_address = rd;
        @(posedge clk);
        #1;
        mdu.start        = 1'b0;
        mdu.funct3       = 3'($urandom_range(0, 7));
        mdu.operand_a    = $urandom;
        mdu.operand_b    = $urandom;
        mdu.dest_address = 5'($urandom_range(0, 31));
        cycles = 0;
        found  = 1'b0;
        while (!found && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mdu.done) found = 1'b1;
            else if (inject && cycles == 10) begin
                mdu.start        = 1'b1;
                mdu.funct3       = 3'b000;
                mdu.operand_a    = 32'd9;
                mdu.operand_b    = 32'd9;
                mdu.dest_address = 5'd7;
            end else if (inject && cycles == 11) begin
                mdu.start = 1'b0;
            end
        end
        check({name, "_latency"}, 32'(cycles), 32'd33);
        check({name, "_data"}, mdu.write_data, exp);
        check({name, "_addr"}, 32'(mdu.write_address), 32'(rd));
        check({name, "_we"}, 32'(mdu.write_enable), (rd != 5'd0) ? 32'd1 : 32'd0);
        check({name, "_busy_fin"}, 32'(mdu.busy), 32'd1);
        @(posedge clk);
        #1;
        check({name, "_done_drop"}, 32'(mdu.done), 32'd0);
        check({name, "_we_drop"}, 32'(mdu.write_enable), 32'd0);
        check({name, "_busy_drop"}, 32'(mdu.busy), 32'd0);
        check({name, "_hold"}, mdu.write_data, exp);
    endtask

    initial begin
        int done_seen;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd8,  32'd14};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd9,  32'd2};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF};
        vecs[9]  = '{3'b110, 32'd5,         32'd0,         5'd11, 32'd5};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000};
        vecs[12] = '{3'b100, 32'hFFFF_FFF9, 32'd0,         5'd31, 32'hFFFF_FFFF};

        rst              = 1'b1;
        mdu.start        = 1'b0;
        mdu.funct3       = 3'b000;
        mdu.operand_a    = '0;
        mdu.operand_b    = '0;
        mdu.dest_address = '0;
        #1;
        check("rst_busy", 32'(mdu.busy), 32'd0);
        check("rst_done", 32'(mdu.done), 32'd0);
        check("rst_we", 32'(mdu.write_enable), 32'd0);
        check("rst_data", mdu.write_data, 32'd0);
        check("rst_addr", 32'(mdu.write_address), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp, 1'b0);
        end

        // rd=0 write suppression with a conflicting start mid-RUN
        run_op("rd0_inject", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("inject_no_restart", 32'(mdu.busy), 32'd0);

        // asynchronous reset 10 cycles into a DIV
        @(negedge clk);
        mdu.start        = 1'b1;
        mdu.funct3       = 3'b100;
        mdu.operand_a    = 32'd1000;
        mdu.operand_b    = 32'd3;
        mdu.dest_address = 5'd15;
        @(posedge clk);
        #1;
        mdu.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(mdu.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mdu.done || mdu.write_enable) done_seen++;
        end
        check("rst_no_done", 32'(done_seen), 32'd0);
        check("rst_idle_busy", 32'(mdu.busy), 32'd0);

        run_op("post_rst_mul", 3'b000, 32'd2, 32'd3, 5'd20, 32'd6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
